// File: rtl/tx_hdmi_timing.sv
// 640x480@60 timing generator: counters -> stage 1 (read strobe, sync decode) -> stage 2 (aligned outputs).
// Mem_Read leads Out_pVDE by one clk so frame-memory data lands aligned with the syncs; no backpressure.
module tx_hdmi_timing #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SelHDMI,
  input  logic [23:0] Mem_Data,
  output logic        Mem_Read,
  output logic [23:0] Out_pData,
  output logic        Out_pHSync,
  output logic        Out_pVSync,
  output logic        Out_pVDE,
  output logic        FraimSync
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int BAR_W = H_ACT / 8;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACT);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACT);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACT + V_FP + V_SYNC - 1);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          act;
  logic          hs_n;
  logic          vs_n;
  logic          frame_pt;
  logic          frame_start;
  logic [2:0]    bar_idx;

  logic          de1;
  logic          hs1;
  logic          vs1;
  logic [2:0]    bar1;
  logic          sel;
  logic [23:0]   pix;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign act         = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
  assign hs_n        = !((hcnt >= HS_BEG) && (hcnt <= HS_END));
  assign vs_n        = !((vcnt >= VS_BEG) && (vcnt <= VS_END));
  assign frame_pt    = (hcnt == '0) && (vcnt == V_ACT_C);
  assign frame_start = (hcnt == '0) && (vcnt == '0);

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (hcnt >= HW'(i * BAR_W)) bar_idx = 3'(i);
    end
  end

  // Source select only moves at the top of a frame, ahead of the first pixel reaching stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Mem_Read  <= 1'b0;
      de1       <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
      bar1      <= 3'd0;
      sel       <= 1'b1;
      FraimSync <= 1'b0;
    end else begin
      Mem_Read  <= act;
      de1       <= act;
      hs1       <= hs_n;
      vs1       <= vs_n;
      bar1      <= bar_idx;
      FraimSync <= frame_pt;
      if (frame_start) sel <= SelHDMI;
    end
  end

  assign pix = sel ? Mem_Data : bar_rgb(bar1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Out_pVDE   <= 1'b0;
      Out_pHSync <= 1'b1;
      Out_pVSync <= 1'b1;
      Out_pData  <= 24'h0;
    end else begin
      Out_pVDE   <= de1;
      Out_pHSync <= hs1;
      Out_pVSync <= vs1;
      Out_pData  <= de1 ? pix : 24'h0;
    end
  end

endmodule

// File: tb/tb_tx_hdmi_timing.sv
// Bench for tx_hdmi_timing: full 800-clk lines with a shortened vertical frame, checked cycle by cycle
// against a time-indexed reference model, plus sync period/width, per-frame counts and reset behaviour.
module tb_tx_hdmi_timing;

  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_ACT  = 6;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;
  localparam int ACT_PER_FRAME = H_ACT * V_ACT;
  localparam logic [28:0] RST_VAL = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SelHDMI = 1'b0;
  logic [23:0] Mem_Data = 24'h0;
  logic        Mem_Read;
  logic [23:0] Out_pData;
  logic        Out_pHSync;
  logic        Out_pVSync;
  logic        Out_pVDE;
  logic        FraimSync;

  tx_hdmi_timing #(
    .V_ACT (V_ACT),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .SelHDMI   (SelHDMI),
    .Mem_Data  (Mem_Data),
    .Mem_Read  (Mem_Read),
    .Out_pData (Out_pData),
    .Out_pHSync(Out_pHSync),
    .Out_pVSync(Out_pVSync),
    .Out_pVDE  (Out_pVDE),
    .FraimSync (FraimSync)
  );

  always #5 clk = ~clk;

  wire [28:0] obs = {Mem_Read, Out_pVDE, Out_pHSync, Out_pVSync, FraimSync, Out_pData};

  int   checks;
  int   errs;
  int   n;
  int   rd_idx;
  int   mr_cnt[4];
  int   de_cnt[4];
  int   fs_cnt[4];
  int   mr_rise;
  int   first_mr;
  int   hs_fall;
  int   vs_fall;
  logic prev_mr, prev_de, prev_hs, prev_vs;
  logic sel_q[5];
  logic plan[5];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    assert (got === exp_v) else begin
      errs++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, got, exp_v);
    end
  endtask

  function automatic logic [23:0] bar_color(input int idx);
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return tbl[idx];
  endfunction

  function automatic logic active_at(input int p);
    int x, y;
    x = p % H_TOT;
    y = (p / H_TOT) % V_TOT;
    return (x < H_ACT) && (y < V_ACT);
  endfunction

  // Outputs visible after the n-th clock since release: stage 1 reflects raster position n-1, stage 2 n-2.
  function automatic logic [28:0] model(input int cyc);
    int p, q, x, y;
    logic mr, fs, de, hs, vs;
    logic [23:0] d;
    p  = cyc - 1;
    mr = active_at(p);
    fs = (p % FRAME) == V_ACT * H_TOT;
    if (cyc == 1) begin
      de = 1'b0; hs = 1'b1; vs = 1'b1; d = 24'h0;
    end else begin
      q  = cyc - 2;
      x  = q % H_TOT;
      y  = (q / H_TOT) % V_TOT;
      de = (x < H_ACT) && (y < V_ACT);
      hs = !((x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SYNC));
      vs = !((y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SYNC));
      if (!de) d = 24'h0;
      else if (sel_q[q / FRAME]) d = {8'h0, 16'(x)};
      else d = bar_color(x / (H_ACT / 8));
    end
    return {mr, de, hs, vs, fs, d};
  endfunction

  task automatic release_rst();
    rst = 1'b0;
    n = 0;
    rd_idx = 0;
    for (int i = 0; i < 4; i++) begin
      mr_cnt[i] = 0; de_cnt[i] = 0; fs_cnt[i] = 0;
    end
    mr_rise = -100; first_mr = -1; hs_fall = -1; vs_fall = -1;
    prev_mr = 1'b0; prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    sel_q[0] = SelHDMI;
  endtask

  task automatic step();
    int ph;
    @(posedge clk);
    #1;
    n++;
    chk("cycle", {3'b0, obs}, {3'b0, model(n)});
    if ((n - 1) / FRAME < 4) begin
      mr_cnt[(n - 1) / FRAME] += int'(Mem_Read);
      fs_cnt[(n - 1) / FRAME] += int'(FraimSync);
    end
    if (n >= 2 && (n - 2) / FRAME < 4) de_cnt[(n - 2) / FRAME] += int'(Out_pVDE);
    if (Mem_Read && !prev_mr) begin
      mr_rise = n;
      if (first_mr < 0) first_mr = n;
    end
    if (Out_pVDE && !prev_de) chk("vde_after_read", 32'(n - mr_rise), 32'd1);
    if (!Out_pHSync && prev_hs) begin
      if (hs_fall < 0) chk("hs_first_fall", 32'(n), 32'd658);
      else chk("hs_period", 32'(n - hs_fall), 32'(H_TOT));
      hs_fall = n;
    end
    if (Out_pHSync && !prev_hs) chk("hs_low", 32'(n - hs_fall), 32'(H_SYNC));
    if (!Out_pVSync && prev_vs) begin
      if (vs_fall >= 0) chk("vs_period", 32'(n - vs_fall), 32'(FRAME));
      vs_fall = n;
    end
    if (Out_pVSync && !prev_vs) chk("vs_low", 32'(n - vs_fall), 32'(V_SYNC * H_TOT));
    prev_mr = Mem_Read; prev_de = Out_pVDE; prev_hs = Out_pHSync; prev_vs = Out_pVSync;
    // Frame memory: one word per strobe, holding the pixel index within the line.
    if (Mem_Read) begin
      Mem_Data = {8'h0, rd_idx[15:0]};
      rd_idx++;
    end else begin
      Mem_Data = 24'($urandom);
      rd_idx = 0;
    end
    ph = n % FRAME;
    if (ph >= 100 && ph < FRAME - 100) begin
      if ($urandom_range(0, 63) == 0) SelHDMI = ~SelHDMI;
    end else if (ph < 100) begin
      SelHDMI = plan[n / FRAME];
    end else begin
      SelHDMI = plan[n / FRAME + 1];
    end
    if (ph == 0) sel_q[n / FRAME] = SelHDMI;
  endtask

  task automatic frame_counts(input int f);
    chk("mem_read_per_frame", 32'(mr_cnt[f]), 32'(ACT_PER_FRAME));
    chk("vde_per_frame", 32'(de_cnt[f]), 32'(ACT_PER_FRAME));
    chk("fraimsync_per_frame", 32'(fs_cnt[f]), 32'd1);
  endtask

  initial begin
    checks = 0;
    errs = 0;
    n = 0;
    plan = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rst = 1'b1;
    SelHDMI = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {3'b0, obs}, {3'b0, RST_VAL});

    // Frame 0 colour bars with mid-frame toggling, frame 1 from memory.
    release_rst();
    while (n < 2 * FRAME + 3 * H_TOT + 300 && errs < 40) step();
    chk("first_read", 32'(first_mr), 32'd1);
    frame_counts(0);
    frame_counts(1);

    // Reset lands mid-line inside the active area; outputs must drop without a clock edge.
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset", {3'b0, obs}, {3'b0, RST_VAL});
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", {3'b0, obs}, {3'b0, RST_VAL});

    SelHDMI = 1'($urandom_range(0, 1));
    plan = '{SelHDMI, ~SelHDMI, 1'b0, 1'b0, 1'b0};
    release_rst();
    while (n < FRAME + 2 && errs < 40) step();
    chk("first_read_after_reset", 32'(first_mr), 32'd1);
    frame_counts(0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
